// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32x32 multiply / 32/32 divide unit owning HI/LO, 33-cycle latency
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, op           - begin op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) when idle
//   rs_val, rt_val      - multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata   - direct HI/LO writes when idle
//   mfhi_req, mflo_req  - pending HI/LO reads, used for stall
//   hi, lo              - architectural HI/LO
//   busy, stall, done   - not idle, pipeline hold, one-cycle completion pulse
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state;
  logic [1:0]  op_r;
  logic [31:0] a, b;
  logic        sa, sb;
  logic [4:0]  cnt;
  logic [63:0] work;
  logic [31:0] mag_rs, mag_rt;
  logic [32:0] acc, rem;
  logic [31:0] sub;
  logic        ge;
  logic [63:0] mul_next, div_next, prod;
  logic        neg_q, neg_r;
  logic [31:0] quo, rem_f;
  assign mag_rs = (~op[0] & rs_val[31]) ? 32'd0 - rs_val : rs_val;
  assign mag_rt = (~op[0] & rt_val[31]) ? 32'd0 - rt_val : rt_val;
  // multiply: work = {partial product, remaining multiplier}; carry lands in bit 63 after the shift
  assign acc      = {1'b0, work[63:32]} + (work[0] ? {1'b0, a} : 33'd0);
  assign mul_next = {acc, work[31:1]};
  // divide: work = {remainder, dividend/quotient}; 33-bit trial keeps the bit shifted out of the remainder
  assign rem      = work[63:31];
  assign ge       = rem >= {1'b0, b};
  assign sub      = rem[31:0] - b;
  assign div_next = ge ? {sub, work[30:0], 1'b1} : {work[62:0], 1'b0};
  assign neg_q    = ~op_r[0] & (sa ^ sb);
  assign neg_r    = ~op_r[0] & sa;
  assign prod     = neg_q ? 64'd0 - work : work;
  assign quo      = neg_q ? 32'd0 - work[31:0] : work[31:0];
  assign rem_f    = neg_r ? 32'd0 - work[63:32] : work[63:32];
  assign busy     = state != IDLE;
  assign stall    = busy & (mfhi_req | mflo_req | start | mthi | mtlo);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_r  <= 2'd0;
      a     <= 32'd0;
      b     <= 32'd0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      cnt   <= 5'd0;
      work  <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a     <= mag_rs;
            b     <= mag_rt;
            sa    <= rs_val[31];
            sb    <= rt_val[31];
            cnt   <= 5'd0;
            work  <= {32'd0, op[1] ? mag_rs : mag_rt};
            state <= RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          work <= op_r[1] ? div_next : mul_next;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          hi    <= op_r[1] ? rem_f : prod[63:32];
          lo    <= op_r[1] ? quo : prod[31:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, mfhi_req, mflo_req;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic [31:0] hi, lo;
  logic        busy, stall, done;
  int compared = 0;
  int mismatched = 0;
  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .mfhi_req(mfhi_req), .mflo_req(mflo_req),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );
  always #5 clk = ~clk;
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bc, output int dc);
    @(negedge clk);
    op = o; rs_val = x; rt_val = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs_val = 32'hDEADBEEF; rt_val = 32'h13572468;
    bc = 0; dc = 0;
    while (busy && bc < 100) begin
      bc++;
      dc += int'(done);
      @(negedge clk);
    end
    dc += int'(done);
    @(negedge clk);
    dc += int'(done);
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfhi_req = 1'b1; mflo_req = 1'b0;
    op = 2'd0; rs_val = 32'd0; rt_val = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    compared++; if (hi !== 32'd0) begin mismatched++; $display("FAIL reset_hi got %h exp %h", hi, 32'd0); end
    compared++; if (lo !== 32'd0) begin mismatched++; $display("FAIL reset_lo got %h exp %h", lo, 32'd0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b exp 0", done); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got %b exp 0", stall); end
    reset = 1'b0; mfhi_req = 1'b0;
  endtask
  task automatic test_mult();
    int bc, dc;
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, bc, dc);
    compared++; if (bc !== 33) begin mismatched++; $display("FAIL mult_busy_cycles got %0d exp 33", bc); end
    compared++; if (dc !== 1) begin mismatched++; $display("FAIL mult_done_pulses got %0d exp 1", dc); end
    compared++; if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    compared++; if (lo !== 32'hFFFFFFEB) begin mismatched++; $display("FAIL mult_lo got %h exp ffffffeb", lo); end
  endtask
  task automatic test_multu_stall();
    int n = 0, st = 0;
    @(negedge clk);
    op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; start = 1'b1; mflo_req = 1'b1;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL multu_idle_stall got %b exp 0", stall); end
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 100) begin
      n++;
      st += int'(stall);
      @(negedge clk);
    end
    compared++; if (n !== 33) begin mismatched++; $display("FAIL multu_busy_cycles got %0d exp 33", n); end
    compared++; if (st !== 33) begin mismatched++; $display("FAIL multu_stall_cycles got %0d exp 33", st); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL multu_stall_after got %b exp 0", stall); end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL multu_done got %b exp 1", done); end
    mflo_req = 1'b0;
    compared++; if (hi !== 32'hFFFFFFFE) begin mismatched++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
    compared++; if (lo !== 32'h00000001) begin mismatched++; $display("FAIL multu_lo got %h exp 00000001", lo); end
  endtask
  task automatic test_div();
    int bc, dc;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, bc, dc);
    compared++; if (lo !== 32'hFFFFFFFD) begin mismatched++; $display("FAIL div_neg_lo got %h exp fffffffd", lo); end
    compared++; if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL div_neg_hi got %h exp ffffffff", hi); end
    compared++; if (dc !== 1) begin mismatched++; $display("FAIL div_neg_done got %0d exp 1", dc); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    compared++; if (lo !== 32'h80000000) begin mismatched++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
    compared++; if (hi !== 32'd0) begin mismatched++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
  endtask
  task automatic test_divu_zero();
    int bc, dc;
    run_op(2'b11, 32'd100, 32'd0, bc, dc);
    compared++; if (bc !== 33) begin mismatched++; $display("FAIL divz_busy_cycles got %0d exp 33", bc); end
    compared++; if (lo !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
    compared++; if (hi !== 32'h00000064) begin mismatched++; $display("FAIL divz_hi got %h exp 00000064", hi); end
  endtask
  task automatic test_moves_busy();
    int n;
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    compared++; if (hi !== 32'h12345678) begin mismatched++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    mtlo = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clk);
    mtlo = 1'b0;
    compared++; if (lo !== 32'h0BADF00D) begin mismatched++; $display("FAIL mtlo_lo got %h exp 0badf00d", lo); end
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'hFFFF0000;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    compared++; if (hi !== 32'h12345678) begin mismatched++; $display("FAIL start_wins_hi got %h exp 12345678", hi); end
    n = 1;
    op = 2'b00; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1; mtlo = 1'b1; wdata = 32'hAAAAAAAA;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL busy_stall got %b exp 1", stall); end
    repeat (5) begin @(negedge clk); n++; end
    start = 1'b0; mtlo = 1'b0;
    compared++; if (lo !== 32'h0BADF00D) begin mismatched++; $display("FAIL busy_mtlo_lo got %h exp 0badf00d", lo); end
    compared++; if (hi !== 32'h12345678) begin mismatched++; $display("FAIL run_hi_stable got %h exp 12345678", hi); end
    while (busy && n < 100) begin @(negedge clk); if (busy) n++; end
    compared++; if (n !== 33) begin mismatched++; $display("FAIL busy_ignore_cycles got %0d exp 33", n); end
    compared++; if (lo !== 32'd14) begin mismatched++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
    compared++; if (hi !== 32'd2) begin mismatched++; $display("FAIL divu_hi got %h exp 00000002", hi); end
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL no_restart_busy got %b exp 0", busy); end
  endtask
  task automatic test_reset_mid();
    int bc, dc, seen;
    @(negedge clk);
    op = 2'b00; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mfhi_req = 1'b1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    compared++; if (hi !== 32'd0) begin mismatched++; $display("FAIL rst_mid_hi got %h exp 00000000", hi); end
    compared++; if (lo !== 32'd0) begin mismatched++; $display("FAIL rst_mid_lo got %h exp 00000000", lo); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rst_mid_stall got %b exp 0", stall); end
    seen = 0;
    repeat (40) begin seen += int'(done) + int'(busy); @(negedge clk); end
    mfhi_req = 1'b0;
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL rst_mid_no_done got %0d exp 0", seen); end
    run_op(2'b00, 32'd3, 32'd4, bc, dc);
    compared++; if (lo !== 32'd12) begin mismatched++; $display("FAIL post_rst_lo got %h exp 0000000c", lo); end
    compared++; if (hi !== 32'd0) begin mismatched++; $display("FAIL post_rst_hi got %h exp 00000000", hi); end
    compared++; if (bc !== 33) begin mismatched++; $display("FAIL post_rst_cycles got %0d exp 33", bc); end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_multu_stall();
    test_div();
    test_divu_zero();
    test_moves_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
